// File: rtl/udp_status_responder.sv
// udp_status_responder
// Transmit-side companion to the UDP receive path. On each request pulse it
// streams one fixed 8-byte status payload into the liteeth udp0_sink port:
//   byte 0..1 magic, 2..3 frame sequence, 4 status, 5..6 rx packet count,
//   7 rx error count.
// Receive traffic is counted by passively tapping the udp0_source handshake.
// One request may be held pending while a packet is in flight; further
// requests are dropped and counted.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req_valid/seq/status    single-cycle send request and its payload fields
//   rx_valid/ready/last/error  taps of the udp0_source stream
//   udp0_sink_*             outgoing byte stream to liteeth
//   busy                    packet in flight or pending slot occupied
//   dropped_count           saturating count of lost requests
module udp_status_responder #(
  parameter logic [7:0] MAGIC_HI = 8'h4C,
  parameter logic [7:0] MAGIC_LO = 8'h43
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_seq,
  input  logic [7:0]  req_status,
  input  logic        rx_valid,
  input  logic        rx_ready,
  input  logic        rx_last,
  input  logic        rx_error,
  output logic        udp0_sink_valid,
  output logic        udp0_sink_last,
  output logic [7:0]  udp0_sink_data,
  input  logic        udp0_sink_ready,
  output logic        busy,
  output logic [7:0]  dropped_count
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;

  logic [15:0] act_seq_q, act_seq_d;
  logic [7:0]  act_status_q, act_status_d;
  logic [15:0] act_pkt_q, act_pkt_d;
  logic [7:0]  act_err_q, act_err_d;

  logic        pend_full_q, pend_full_d;
  logic [15:0] pend_seq_q, pend_seq_d;
  logic [7:0]  pend_status_q, pend_status_d;
  logic [15:0] pend_pkt_q, pend_pkt_d;
  logic [7:0]  pend_err_q, pend_err_d;

  logic [15:0] rx_pkt_count_q, rx_pkt_count_d;
  logic [7:0]  rx_err_count_q, rx_err_count_d;
  logic [7:0]  dropped_q, dropped_d;

  logic pkt_end;
  logic beat_fire;
  logic last_fire;

  assign pkt_end   = rx_valid & rx_ready & rx_last;
  assign beat_fire = (state_q == StSend) & udp0_sink_ready;
  assign last_fire = beat_fire & (idx_q == 3'd7);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    act_seq_d      = act_seq_q;
    act_status_d   = act_status_q;
    act_pkt_d      = act_pkt_q;
    act_err_d      = act_err_q;
    pend_full_d    = pend_full_q;
    pend_seq_d     = pend_seq_q;
    pend_status_d  = pend_status_q;
    pend_pkt_d     = pend_pkt_q;
    pend_err_d     = pend_err_q;
    rx_pkt_count_d = rx_pkt_count_q;
    rx_err_count_d = rx_err_count_q;
    dropped_d      = dropped_q;

    // Counting is independent of the transmit state.
    if (pkt_end) begin
      rx_pkt_count_d = rx_pkt_count_q + 16'd1;
      if (rx_error && (rx_err_count_q != 8'hFF)) begin
        rx_err_count_d = rx_err_count_q + 8'd1;
      end
    end

    // Snapshots below use the _q counters, i.e. values before this cycle's count.
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          act_seq_d    = req_seq;
          act_status_d = req_status;
          act_pkt_d    = rx_pkt_count_q;
          act_err_d    = rx_err_count_q;
          idx_d        = 3'd0;
          state_d      = StSend;
        end
      end
      StSend: begin
        if (beat_fire) begin
          idx_d = idx_q + 3'd1;
        end
        if (last_fire) begin
          if (pend_full_q) begin
            act_seq_d    = pend_seq_q;
            act_status_d = pend_status_q;
            act_pkt_d    = pend_pkt_q;
            act_err_d    = pend_err_q;
            if (req_valid) begin
              // The freed pending slot takes the new request, so nothing is lost.
              pend_seq_d    = req_seq;
              pend_status_d = req_status;
              pend_pkt_d    = rx_pkt_count_q;
              pend_err_d    = rx_err_count_q;
            end else begin
              pend_full_d = 1'b0;
            end
          end else if (req_valid) begin
            act_seq_d    = req_seq;
            act_status_d = req_status;
            act_pkt_d    = rx_pkt_count_q;
            act_err_d    = rx_err_count_q;
          end else begin
            state_d = StIdle;
          end
        end else if (req_valid) begin
          if (!pend_full_q) begin
            pend_full_d   = 1'b1;
            pend_seq_d    = req_seq;
            pend_status_d = req_status;
            pend_pkt_d    = rx_pkt_count_q;
            pend_err_d    = rx_err_count_q;
          end else if (dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= 3'd0;
      act_seq_q      <= 16'd0;
      act_status_q   <= 8'd0;
      act_pkt_q      <= 16'd0;
      act_err_q      <= 8'd0;
      pend_full_q    <= 1'b0;
      pend_seq_q     <= 16'd0;
      pend_status_q  <= 8'd0;
      pend_pkt_q     <= 16'd0;
      pend_err_q     <= 8'd0;
      rx_pkt_count_q <= 16'd0;
      rx_err_count_q <= 8'd0;
      dropped_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      act_seq_q      <= act_seq_d;
      act_status_q   <= act_status_d;
      act_pkt_q      <= act_pkt_d;
      act_err_q      <= act_err_d;
      pend_full_q    <= pend_full_d;
      pend_seq_q     <= pend_seq_d;
      pend_status_q  <= pend_status_d;
      pend_pkt_q     <= pend_pkt_d;
      pend_err_q     <= pend_err_d;
      rx_pkt_count_q <= rx_pkt_count_d;
      rx_err_count_q <= rx_err_count_d;
      dropped_q      <= dropped_d;
    end
  end

  // Outputs derive only from registered state, so they hold while stalled.
  always_comb begin
    udp0_sink_data = 8'h00;
    if (state_q == StSend) begin
      case (idx_q)
        3'd0:    udp0_sink_data = MAGIC_HI;
        3'd1:    udp0_sink_data = MAGIC_LO;
        3'd2:    udp0_sink_data = act_seq_q[15:8];
        3'd3:    udp0_sink_data = act_seq_q[7:0];
        3'd4:    udp0_sink_data = act_status_q;
        3'd5:    udp0_sink_data = act_pkt_q[15:8];
        3'd6:    udp0_sink_data = act_pkt_q[7:0];
        default: udp0_sink_data = act_err_q;
      endcase
    end
  end

  assign udp0_sink_valid = (state_q == StSend);
  assign udp0_sink_last  = (state_q == StSend) & (idx_q == 3'd7);
  assign busy            = (state_q == StSend) | pend_full_q;
  assign dropped_count   = dropped_q;

endmodule

// File: doc/udp_status_responder.md
Name: udp_status_responder

Overview:
- Transmit-side companion to the UDP receive path. Sits between the frame/packet logic and the liteeth core's udp0_sink stream.
- On each request pulse, emits one fixed 8-byte UDP status payload to the host: magic, frame sequence, status byte, and snapshots of receive packet/error counters.
- Counts receive traffic itself by passively tapping the udp0_source handshake signals.
- Holds one pending request while a send is in flight.

Parameters:
- MAGIC_HI, 8'h4C, payload byte 0
- MAGIC_LO, 8'h43, payload byte 1

Ports:
- clock  in  1  system clock (same domain as liteeth sys_clock)
- reset  in  1  synchronous, active-high
- req_valid  in  1  single-cycle send request
- req_seq  in  16  frame sequence number for the request
- req_status  in  8  status code for the request
- rx_valid  in  1  tap of udp0_source_valid
- rx_ready  in  1  tap of udp0_source_ready
- rx_last  in  1  tap of udp0_source_last
- rx_error  in  1  tap of udp0_source_error
- udp0_sink_valid  out  1  stream valid to liteeth
- udp0_sink_last  out  1  marks byte 7
- udp0_sink_data  out  8  payload byte
- udp0_sink_ready  in  1  stream ready from liteeth
- busy  out  1  high in SEND or while the pending slot is full
- dropped_count  out  8  requests lost because both slots were full; saturates at 255

Behaviour:
- Reset (synchronous, active-high): state=IDLE; pending slot empty; rx_pkt_count=0; rx_err_count=0; dropped_count=0; udp0_sink_valid=0; udp0_sink_last=0; udp0_sink_data=0; busy=0. Reset during SEND abandons the packet immediately; last is never asserted for it.
- Receive counters:
  - A packet end is a cycle with rx_valid & rx_ready & rx_last.
  - Each packet end increments rx_pkt_count (16-bit, wraps 0xFFFF→0).
  - If rx_error is also high, rx_err_count increments (8-bit, saturates at 255).
  - Counting runs in every state.
- Snapshot: when a request is accepted (into active or pending), latch seq, status, and the counters. Counter values are those before that cycle's increment.
- Payload byte index 0..7:
  - 0: MAGIC_HI
  - 1: MAGIC_LO
  - 2: seq[15:8]
  - 3: seq[7:0]
  - 4: status
  - 5: pkt[15:8]
  - 6: pkt[7:0]
  - 7: err
- FSM states: IDLE, SEND.
  - IDLE with req_valid in cycle N: load active. In cycle N+1: SEND, valid=1, data=byte0, idx=0.
  - SEND: a beat transfers when valid & ready; idx then increments.
  - udp0_sink_data, udp0_sink_last and udp0_sink_valid stay stable while valid & !ready.
  - last=1 exactly when idx=7.
- Last beat accepted:
  - If pending is full: move pending to active. Next cycle starts byte0 with valid held high (back-to-back, no gap).
  - Else if req_valid in the same cycle: load it directly into active, back-to-back.
  - Else: go to IDLE; valid=0 next cycle.
- req_valid in SEND (not on the last-beat cycle):
  - Pending empty: store in pending.
  - Pending full: drop the request; dropped_count++ (saturating).
- req_valid on the last-beat cycle with pending full: pending moves to active, and the new request fills the freed pending slot (no drop).
- busy = (state==SEND) | pending_full.
- udp0_sink_data is 0 when valid=0.

Test Plan:
- Reset, then req_valid at cycle 10 with seq=0x1234, status=0xA5, ready held 1 → valid rises at cycle 11. Bytes 4C 43 12 34 A5 00 00 00; last only on the 8th byte; valid low at cycle 19; busy low after.
- 3 rx packet ends, one with rx_error=1, then a request with seq=1, ready=1 → bytes 5..7 = 00 03 01. A packet end in the same cycle as the request is excluded from this snapshot and counted in the next one.
- Request sent with ready toggling 1,0,0,1,… → each byte is held stable while ready=0. Exactly 8 transfers, in order, last on the 8th.
- Three requests (seq 1, 2, 3) during one SEND with ready=0 → seq1 active, seq2 pending, seq3 dropped, dropped_count=1. With ready=1 after, two packets go out back-to-back with no valid gap: seq1 then seq2.
- req_valid on the last-beat cycle with pending empty (seq=7) → the next cycle is byte0 of seq=7, valid continuous. 300 dropped requests → dropped_count stays at 255.
- Reset asserted at byte 3 of a packet → next cycle valid=0, counters 0, pending empty. The next request sends a full fresh packet starting with 4C.
